// File: rtl/mnist_pkg.sv
// ============================================================================
// Module   : mnist_pkg
// Brief    : Shared image geometry defaults and streamer FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mnist_pkg;

  localparam int IMG_W_DEFAULT = 28;
  localparam int IMG_H_DEFAULT = 28;
  localparam int NUM_PIXELS    = IMG_W_DEFAULT * IMG_H_DEFAULT;
  localparam int ADDR_W        = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_RESULT = 2'd2,
    DONE        = 2'd3
  } stream_state_t;

endpackage : mnist_pkg

`default_nettype wire

// File: rtl/image_streamer_if.sv
// ============================================================================
// Module   : image_streamer_if
// Brief    : Host/classifier-side signal bundle of the image streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface image_streamer_if
  import mnist_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IMG_W-1:0]  wr_data;
  logic              start;
  logic              busy;
  logic              pixel_out;
  logic              pixel_valid;
  logic              result_valid_in;
  logic [3:0]        prediction_in;
  logic [7:0]        confidence_in;
  logic              done;
  logic [3:0]        prediction;
  logic [7:0]        confidence;
  logic              timeout_err;

  // Host / classifier side
  modport master (
    output wr_en, wr_addr, wr_data, start,
    output result_valid_in, prediction_in, confidence_in,
    input  busy, pixel_out, pixel_valid, done, prediction, confidence, timeout_err
  );

  // Streamer side
  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    input  result_valid_in, prediction_in, confidence_in,
    output busy, pixel_out, pixel_valid, done, prediction, confidence, timeout_err
  );

endinterface : image_streamer_if

`default_nettype wire

// File: rtl/image_row_buffer.sv
// ============================================================================
// Module   : image_row_buffer
// Brief    : IMG_H x IMG_W row store, one synchronous write port and one
//            combinational read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_row_buffer
  import mnist_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [IMG_W-1:0]  wr_data,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [IMG_W-1:0]  rd_data
);

  logic [IMG_W-1:0] r_mem [IMG_H];

  logic w_wr_in_range;
  logic w_rd_in_range;

  assign w_wr_in_range = (32'(wr_addr) < IMG_H);
  assign w_rd_in_range = (32'(rd_addr) < IMG_H);

  always_ff @(posedge clk) begin
    if (wr_en && w_wr_in_range) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range reads return zero so the caller never sees X from a lookahead.
  assign rd_data = w_rd_in_range ? r_mem[rd_addr] : '0;

endmodule : image_row_buffer

`default_nettype wire

// File: rtl/image_streamer.sv
// ============================================================================
// Module   : image_streamer
// Brief    : Buffers an image row by row, streams it bit-serially to a
//            classifier and captures the classifier result with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_streamer
  import mnist_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEFAULT,
  parameter int IMG_H   = IMG_H_DEFAULT,
  parameter int TIMEOUT = 4096
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  image_streamer_if.slave  bus
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [COL_W-1:0]  C_COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] C_ROW_LAST  = ADDR_W'(IMG_H - 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  stream_state_t     r_state;
  logic              r_busy;
  logic              r_pixel_out;
  logic              r_pixel_valid;
  logic              r_done;
  logic              r_timeout_err;
  logic [3:0]        r_prediction;
  logic [7:0]        r_confidence;
  logic [ADDR_W-1:0] r_row;
  logic [COL_W-1:0]  r_col;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              w_buf_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [IMG_W-1:0]  w_rd_data;
  logic [IMG_W-1:0]  w_first_row;
  logic              w_col_wrap;
  logic [COL_W-1:0]  w_next_col;
  logic [ADDR_W-1:0] w_next_row;
  logic              w_last_pixel;

  // Row/column counters address the pixel currently on pixel_out.
  assign w_col_wrap   = (r_col == C_COL_LAST);
  assign w_next_col   = w_col_wrap ? '0 : r_col + 1'b1;
  assign w_next_row   = w_col_wrap ? r_row + 1'b1 : r_row;
  assign w_last_pixel = w_col_wrap && (r_row == C_ROW_LAST);

  assign w_buf_we  = (r_state == IDLE) && bus.wr_en;
  assign w_rd_addr = (r_state == STREAM) ? w_next_row : '0;

  // A row-0 write on the start edge is not yet in the buffer; forward it.
  assign w_first_row = (w_buf_we && (bus.wr_addr == '0)) ? bus.wr_data : w_rd_data;

  image_row_buffer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (w_buf_we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_pixel_out   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_prediction  <= '0;
      r_confidence  <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state       <= STREAM;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_pixel_valid <= 1'b1;
            r_pixel_out   <= w_first_row[0];
          end
        end

        STREAM: begin
          if (w_last_pixel) begin
            r_state       <= WAIT_RESULT;
            r_pixel_valid <= 1'b0;
            r_pixel_out   <= 1'b0;
            r_wait_cnt    <= '0;
          end else begin
            r_row       <= w_next_row;
            r_col       <= w_next_col;
            r_pixel_out <= w_rd_data[w_next_col];
          end
        end

        WAIT_RESULT: begin
          if (bus.result_valid_in) begin
            r_state      <= DONE;
            r_done       <= 1'b1;
            r_prediction <= bus.prediction_in;
            r_confidence <= bus.confidence_in;
          end else if (r_wait_cnt == C_WAIT_LAST) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state       <= IDLE;
          r_busy        <= 1'b0;
          r_pixel_valid <= 1'b0;
          r_pixel_out   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.pixel_out   = r_pixel_out;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.done        = r_done;
  assign bus.prediction  = r_prediction;
  assign bus.confidence  = r_confidence;
  assign bus.timeout_err = r_timeout_err;

endmodule : image_streamer

`default_nettype wire

// File: tb/tb_image_streamer.sv
// ============================================================================
// Module   : tb_image_streamer
// Brief    : Self-checking bench for image_streamer against an image-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_streamer;
  import mnist_pkg::*;

  localparam int W  = IMG_W_DEFAULT;
  localparam int H  = IMG_H_DEFAULT;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] img [H];

  image_streamer_if #(.IMG_W(W)) bus ();

  image_streamer #(
    .IMG_W   (W),
    .IMG_H   (H),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_image();
    for (int r = 0; r < H; r++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(r);
      bus.wr_data = img[r];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  // Caller raises start (and optionally a write) before calling.
  task automatic run_stream(input string tag, input bit noisy);
    int bad;
    logic exp_bit;
    bad = 0;
    check({tag, "_pre_valid"}, 32'(bus.pixel_valid), 0);
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check({tag, "_terr_clr"}, 32'(bus.timeout_err), 0);
    for (int p = 0; p < NUM_PIXELS; p++) begin
      exp_bit = img[p / W][p % W];
      if (bus.pixel_valid !== 1'b1 || bus.pixel_out !== exp_bit || bus.busy !== 1'b1)
        bad++;
      if (noisy) begin
        bus.start           = 1'($urandom_range(0, 1));
        bus.wr_en           = 1'b1;
        bus.wr_addr         = ADDR_W'(3);
        bus.wr_data         = W'($urandom);
        bus.result_valid_in = 1'($urandom_range(0, 1));
        bus.prediction_in   = 4'($urandom);
        bus.confidence_in   = 8'($urandom);
      end
      tick();
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.result_valid_in = 1'b0;
    check({tag, "_bad_pixels"}, 32'(bad), 0);
    check({tag, "_post_valid"}, {30'd0, bus.pixel_valid, bus.pixel_out}, 0);
    check({tag, "_wait_busy"}, 32'(bus.busy), 1);
  endtask

  task automatic capture(input string tag, input logic [3:0] pred, input logic [7:0] conf);
    bus.result_valid_in = 1'b1;
    bus.prediction_in   = pred;
    bus.confidence_in   = conf;
    tick();
    bus.result_valid_in = 1'b0;
    bus.prediction_in   = 4'($urandom);
    bus.confidence_in   = 8'($urandom);
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_pred"}, 32'(bus.prediction), 32'(pred));
    check({tag, "_conf"}, 32'(bus.confidence), 32'(conf));
    tick();
    check({tag, "_done_drop"}, {30'd0, bus.done, bus.busy}, 0);
  endtask

  initial begin
    int rise;
    logic [3:0] pred;
    logic [7:0] conf;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
    bus.result_valid_in = 1'b0; bus.prediction_in = '0; bus.confidence_in = '0;

    repeat (3) tick();
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_pvalid", 32'(bus.pixel_valid), 0);
    check("rst_pout",  32'(bus.pixel_out), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_terr",  32'(bus.timeout_err), 0);
    check("rst_pred",  32'(bus.prediction), 0);
    check("rst_conf",  32'(bus.confidence), 0);
    rst_n = 1'b1;
    tick();

    // Diagonal image with noise on start/wr_en/result during the stream.
    for (int r = 0; r < H; r++) img[r] = W'(1) << r;
    write_image();
    bus.start = 1'b1;
    run_stream("diag", 1'b1);
    check("diag_pred_hold", 32'(bus.prediction), 0);
    repeat (3) tick();
    check("diag_no_done", 32'(bus.done), 0);
    capture("cap1", 4'd7, 8'd92);

    // Timeout run on a random image, row 3 unchanged by the previous noise.
    for (int r = 0; r < H; r++) img[r] = W'($urandom);
    write_image();
    img[3] = W'(1) << 3;
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(3); bus.wr_data = img[3];
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    run_stream("tmo", 1'b1);
    rise = 0;
    for (int k = 1; k <= TO + 4 && rise == 0; k++) begin
      tick();
      if (bus.timeout_err === 1'b1) rise = k;
    end
    check("tmo_cycles", 32'(rise), TO);
    check("tmo_busy", 32'(bus.busy), 0);
    check("tmo_pred", 32'(bus.prediction), 7);
    check("tmo_conf", 32'(bus.confidence), 92);

    // Row-0 write on the start edge must reach the stream.
    img[0] = W'($urandom) | W'(1);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = img[0];
    bus.start = 1'b1;
    run_stream("simul", 1'b0);
    pred = 4'($urandom); conf = 8'($urandom);
    repeat (5) tick();
    capture("cap2", pred, conf);

    // Out-of-range writes leave the image untouched.
    for (int a = H; a < 32; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = W'($urandom);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    run_stream("oor", 1'b0);
    capture("cap3", 4'd9, 8'd255);

    // Reset in the middle of a stream.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (400) tick();
    check("mid_pvalid_before", 32'(bus.pixel_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {bus.busy, bus.pixel_valid, bus.pixel_out, bus.done, bus.timeout_err}, 0);
    check("mid_rst_pc", {bus.prediction, bus.confidence}, 0);
    tick();
    rst_n = 1'b1;
    rise = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0) rise++;
    end
    check("mid_rst_quiet", 32'(rise), 0);

    // Fresh random image after reset.
    for (int r = 0; r < H; r++) img[r] = W'($urandom);
    write_image();
    bus.start = 1'b1;
    run_stream("final", 1'b1);
    pred = 4'($urandom); conf = 8'($urandom);
    capture("cap4", pred, conf);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_image_streamer

`default_nettype wire
